instr_fetch: RTL

Upstream sequencer for the simple processor. Fetches 16-bit instruction words from a synchronous-read instruction memory and presents each on `ir` with a one-cycle `run` pulse to the control FSM. It then waits for the FSM's `done` before fetching the next word. It also detects the HALT marker, counts retired instructions and runs a watchdog against a hung control FSM.

---
 rtl/instr_fetch_pkg.sv | 40 ++++
 rtl/instr_fetch_watchdog.sv | 39 +++
 rtl/instr_fetch.sv | 105 ++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer and the control FSM:
// opcode values, instruction field positions and the fetch state encoding.
package instr_fetch_pkg;

  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned HALT_BIT = 15;
  localparam int unsigned ICODE_HI = 14;
  localparam int unsigned ICODE_LO = 13;
  localparam int unsigned IREG_BIT = 12;
  localparam int unsigned RX_HI    = 11;
  localparam int unsigned RX_LO    = 9;
  localparam int unsigned RY_HI    = 2;
  localparam int unsigned RY_LO    = 0;

  typedef enum logic [1:0] {
    OP_MV  = 2'd0,
    OP_MVT = 2'd1,
    OP_ADD = 2'd2,
    OP_SUB = 2'd3
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_EXEC,
    S_HALTED,
    S_FAULT
  } fetch_state_e;

  function automatic logic is_halt(input logic [INSTR_W-1:0] word);
    return word[HALT_BIT];
  endfunction

  function automatic opcode_e icode_of(input logic [INSTR_W-1:0] word);
    return opcode_e'(word[ICODE_HI:ICODE_LO]);
  endfunction

endpackage

// File: rtl/instr_fetch_watchdog.sv
// Execution watchdog: counts enabled cycles since the last clear and flags the
// cycle on which the TIMEOUT-th enabled cycle is being spent.
module fetch_watchdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] TOP  = CW'(TIMEOUT);

  logic [CW-1:0] count_q, count_d;

  // count_q holds completed cycles, so the current cycle is count_q + 1
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != TOP)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = en && !clr && (count_q == LAST);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: reads a word, hands it to the control FSM with a
// one-cycle run pulse, waits for done, and stops on HALT or a watchdog fault.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned AW      = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [15:0]   mem_rdata,
  output logic [15:0]   ir,
  output logic          run,
  input  logic          done,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic          fault,
  output logic [15:0]   icount
);

  fetch_state_e         state_q, state_d;
  logic [AW-1:0]        pc_q, pc_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [15:0]          icount_q, icount_d;
  logic                 wd_clr, wd_en, wd_expired;

  assign wd_clr = (state_q == S_ISSUE);
  assign wd_en  = (state_q == S_EXEC);

  fetch_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    icount_d = icount_q;
    unique case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          pc_d     = '0;
          icount_d = '0;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        ir_d    = mem_rdata;
        state_d = is_halt(mem_rdata) ? S_HALTED : S_ISSUE;
      end
      // done is not looked at here: the control FSM holds it high while idle
      S_ISSUE: state_d = S_EXEC;
      S_EXEC: begin
        if (done) begin
          pc_d = pc_q + AW'(1);
          if (icount_q != '1) begin
            icount_d = icount_q + 16'd1;
          end
          state_d = S_FETCH;
        end else if (wd_expired) begin
          state_d = S_FAULT;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      icount_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      icount_q <= icount_d;
    end
  end

  assign mem_rd   = (state_q == S_FETCH);
  assign mem_addr = pc_q;
  assign run      = (state_q == S_ISSUE);
  assign busy     = (state_q == S_FETCH) || (state_q == S_WAIT) ||
                    (state_q == S_ISSUE) || (state_q == S_EXEC);
  assign halted   = (state_q == S_HALTED);
  assign fault    = (state_q == S_FAULT);
  assign ir       = ir_q;
  assign pc       = pc_q;
  assign icount   = icount_q;

endmodule
